// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the async FIFO: pops words through the FIFO read port
// and re-times them onto a valid/ready stream through a 2-entry register buffer.
module fifo_rd_stream #(
   parameter int Data_width = 8,
   parameter int RD_LAT     = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  Rempty,
   input  logic [Data_width-1:0] Rdata,
   output logic                  Rinc,
   output logic [Data_width-1:0] Out_data,
   output logic                  Out_valid,
   input  logic                  Out_ready,
   output logic [CNT_W-1:0]      Word_cnt
);

   logic [1:0]            occ;
   logic                  infl;
   logic [Data_width-1:0] head_data;
   logic [Data_width-1:0] tail_data;
   logic                  pop;
   logic                  cap;
   logic [2:0]            committed;
   logic [1:0]            wr_pos;

   // Request stage: words already held or in flight count against the two slots,
   // and a same-cycle pop frees one, so backpressure can never overflow the buffer.
   always_comb begin
      pop       = Out_valid & Out_ready;
      committed = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
      Rinc      = ~RST & ~Rempty & (committed < 3'd2);
      cap       = (RD_LAT == 0) ? Rinc : infl;
      wr_pos    = occ - {1'b0, pop};
   end

   // Capture stage: a pop shifts the tail forward first, then the captured word
   // lands behind whatever remains, keeping the stream in order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         occ       <= 2'd0;
         infl      <= 1'b0;
         head_data <= '0;
         tail_data <= '0;
         Word_cnt  <= '0;
      end else begin
         infl <= (RD_LAT != 0) & Rinc;
         occ  <= occ + {1'b0, cap} - {1'b0, pop};
         if (pop) begin
            head_data <= tail_data;
            Word_cnt  <= Word_cnt + CNT_W'(1);
         end
         if (cap) begin
            if (wr_pos == 2'd0) begin
               head_data <= Rdata;
            end else begin
               tail_data <= Rdata;
            end
         end
      end
   end

   assign Out_valid = (occ != 2'd0);
   assign Out_data  = head_data;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: one RD_LAT=1/CNT_W=4 instance and one RD_LAT=0 instance,
// each fed by a small behavioural FIFO read port, with scoreboard queues of expected words.
module tb_fifo_rd_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Instance A: registered FIFO read data, narrow counter
   logic       rempty_a, rinc_a, out_valid_a, out_ready_a;
   logic [7:0] rdata_a, out_data_a;
   logic [3:0] word_cnt_a;
   logic [7:0] mem_a [0:255];
   logic [7:0] wp_a;
   logic [7:0] rp_a = 8'd0;

   // Instance B: combinational FIFO read data, with a forced-empty override
   logic        rempty_b, rinc_b, out_valid_b, out_ready_b, force_empty_b;
   logic [7:0]  rdata_b, out_data_b;
   logic [15:0] word_cnt_b;
   logic [7:0]  mem_b [0:255];
   logic [7:0]  wp_b;
   logic [7:0]  rp_b = 8'd0;

   logic [7:0]  sb_a[$];
   logic [7:0]  sb_b[$];
   logic [3:0]  exp_cnt_a;
   logic [15:0] exp_cnt_b;
   int checks;
   int errors;

   fifo_rd_stream #(.Data_width(8), .RD_LAT(1), .CNT_W(4)) dut_a (
      .CLK(clk), .RST(rst), .Rempty(rempty_a), .Rdata(rdata_a), .Rinc(rinc_a),
      .Out_data(out_data_a), .Out_valid(out_valid_a), .Out_ready(out_ready_a),
      .Word_cnt(word_cnt_a)
   );

   fifo_rd_stream #(.Data_width(8), .RD_LAT(0), .CNT_W(16)) dut_b (
      .CLK(clk), .RST(rst), .Rempty(rempty_b), .Rdata(rdata_b), .Rinc(rinc_b),
      .Out_data(out_data_b), .Out_valid(out_valid_b), .Out_ready(out_ready_b),
      .Word_cnt(word_cnt_b)
   );

   assign rempty_a = (wp_a == rp_a);
   always @(posedge clk) begin
      if (rinc_a) begin
         rdata_a <= mem_a[rp_a];
         rp_a    <= rp_a + 8'd1;
      end
   end

   assign rempty_b = (wp_b == rp_b) | force_empty_b;
   assign rdata_b  = mem_b[rp_b];
   always @(posedge clk) begin
      if (rinc_b) rp_b <= rp_b + 8'd1;
   end

   task automatic test_reset();
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (k == 3) rst = 1'b0;
         #1;
         checks++;
         if (rinc_a !== 1'b0 || rinc_b !== 1'b0) begin
            errors++; $display("FAIL reset_rinc cyc %0d: got %b/%b want 0/0", k, rinc_a, rinc_b);
         end
         checks++;
         if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
            errors++; $display("FAIL reset_valid cyc %0d: got %b/%b want 0/0", k, out_valid_a, out_valid_b);
         end
         checks++;
         if (out_data_a !== 8'h00 || out_data_b !== 8'h00) begin
            errors++; $display("FAIL reset_data cyc %0d: got %h/%h want 00/00", k, out_data_a, out_data_b);
         end
         checks++;
         if (word_cnt_a !== 4'd0 || word_cnt_b !== 16'd0) begin
            errors++; $display("FAIL reset_cnt cyc %0d: got %0d/%0d want 0/0", k, word_cnt_a, word_cnt_b);
         end
      end
   endtask

   task automatic test_stream_lat1();
      logic [5:0] exp_rinc = 6'b000111;
      logic [5:0] exp_vld  = 6'b011100;
      logic [7:0] w;
      @(posedge clk); #1;
      out_ready_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         w = 8'(8'h11 * (i + 1));
         mem_a[wp_a] = w; wp_a = wp_a + 8'd1; sb_a.push_back(w);
      end
      for (int k = 0; k < 6; k++) begin
         #1;
         checks++;
         if (rinc_a !== exp_rinc[k]) begin
            errors++; $display("FAIL lat1_rinc cyc %0d: got %b want %b", k, rinc_a, exp_rinc[k]);
         end
         checks++;
         if (out_valid_a !== exp_vld[k]) begin
            errors++; $display("FAIL lat1_valid cyc %0d: got %b want %b", k, out_valid_a, exp_vld[k]);
         end
         if (out_valid_a === 1'b1) begin
            checks++;
            if (sb_a.size() == 0) begin
               errors++; $display("FAIL lat1_data: got unexpected %h want none", out_data_a);
            end else begin
               w = sb_a.pop_front();
               if (out_data_a !== w) begin
                  errors++; $display("FAIL lat1_data: got %h want %h", out_data_a, w);
               end
            end
            exp_cnt_a = exp_cnt_a + 4'd1;
         end
         @(posedge clk); #1;
      end
      #1;
      checks++;
      if (word_cnt_a !== exp_cnt_a) begin
         errors++; $display("FAIL lat1_cnt: got %0d want %0d", word_cnt_a, exp_cnt_a);
      end
      checks++;
      if (sb_a.size() != 0) begin
         errors++; $display("FAIL lat1_drain: got %0d pending want 0", sb_a.size());
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] w;
      int pulses = 0;
      int got = 0;
      bit started = 0;
      @(posedge clk); #1;
      out_ready_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         w = 8'(8'hA0 + i);
         mem_a[wp_a] = w; wp_a = wp_a + 8'd1; sb_a.push_back(w);
      end
      for (int k = 0; k < 8; k++) begin
         #1;
         if (rinc_a === 1'b1) pulses++;
         if (k >= 2) begin
            checks++;
            if (out_valid_a !== 1'b1 || out_data_a !== sb_a[0]) begin
               errors++; $display("FAIL bp_hold cyc %0d: got %b/%h want 1/%h", k, out_valid_a, out_data_a, sb_a[0]);
            end
         end
         @(posedge clk); #1;
      end
      checks++;
      if (pulses != 2) begin
         errors++; $display("FAIL bp_pulses: got %0d want 2", pulses);
      end
      out_ready_a = 1'b1;
      for (int k = 0; k < 12; k++) begin
         #1;
         checks++;
         if (rinc_a === 1'b1 && rempty_a === 1'b1) begin
            errors++; $display("FAIL bp_rinc_empty cyc %0d: got rinc 1 want 0", k);
         end
         if (out_valid_a === 1'b1) begin
            started = 1;
            got++;
            checks++;
            if (sb_a.size() == 0) begin
               errors++; $display("FAIL bp_data: got unexpected %h want none", out_data_a);
            end else begin
               w = sb_a.pop_front();
               if (out_data_a !== w) begin
                  errors++; $display("FAIL bp_data: got %h want %h", out_data_a, w);
               end
            end
            exp_cnt_a = exp_cnt_a + 4'd1;
         end else if (started && got < 5) begin
            checks++; errors++;
            $display("FAIL bp_gap cyc %0d: got valid 0 want 1", k);
         end
         @(posedge clk); #1;
      end
      #1;
      checks++;
      if (got != 5) begin
         errors++; $display("FAIL bp_count: got %0d want 5", got);
      end
      checks++;
      if (word_cnt_a !== exp_cnt_a) begin
         errors++; $display("FAIL bp_cnt: got %0d want %0d", word_cnt_a, exp_cnt_a);
      end
      checks++;
      if (rempty_a !== 1'b1) begin
         errors++; $display("FAIL bp_empty: got %b want 1", rempty_a);
      end
   endtask

   task automatic test_alternating_empty();
      logic [7:0] w;
      logic exp_rinc;
      logic prev = 1'b0;
      @(posedge clk); #1;
      out_ready_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         w = 8'(8'hB0 + i);
         mem_b[wp_b] = w; wp_b = wp_b + 8'd1; sb_b.push_back(w);
      end
      for (int k = 0; k < 14; k++) begin
         force_empty_b = (k % 2 == 1);
         #1;
         exp_rinc = ~rempty_b;
         checks++;
         if (rinc_b !== exp_rinc) begin
            errors++; $display("FAIL alt_rinc cyc %0d: got %b want %b", k, rinc_b, exp_rinc);
         end
         checks++;
         if (out_valid_b !== prev) begin
            errors++; $display("FAIL alt_valid cyc %0d: got %b want %b", k, out_valid_b, prev);
         end
         if (out_valid_b === 1'b1) begin
            checks++;
            if (sb_b.size() == 0) begin
               errors++; $display("FAIL alt_data: got unexpected %h want none", out_data_b);
            end else begin
               w = sb_b.pop_front();
               if (out_data_b !== w) begin
                  errors++; $display("FAIL alt_data: got %h want %h", out_data_b, w);
               end
            end
            exp_cnt_b = exp_cnt_b + 16'd1;
         end
         prev = exp_rinc;
         @(posedge clk); #1;
      end
      force_empty_b = 1'b0;
      #1;
      checks++;
      if (word_cnt_b !== exp_cnt_b) begin
         errors++; $display("FAIL alt_cnt: got %0d want %0d", word_cnt_b, exp_cnt_b);
      end
      checks++;
      if (sb_b.size() != 0) begin
         errors++; $display("FAIL alt_drain: got %0d pending want 0", sb_b.size());
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      out_ready_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mem_a[wp_a] = 8'(8'hC0 + i); wp_a = wp_a + 8'd1;
      end
      repeat (4) begin
         @(posedge clk); #1;
      end
      #1;
      checks++;
      if (out_valid_a !== 1'b1 || out_data_a !== 8'hC0) begin
         errors++; $display("FAIL rstmid_pre: got %b/%h want 1/c0", out_valid_a, out_data_a);
      end
      rst = 1'b1;
      out_ready_a = 1'b1;
      #1;
      checks++;
      if (rinc_a !== 1'b0) begin
         errors++; $display("FAIL rstmid_rinc: got %b want 0", rinc_a);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      wp_a = rp_a;
      sb_a.delete();
      exp_cnt_a = 4'd0;
      exp_cnt_b = 16'd0;
      #1;
      checks++;
      if (out_valid_a !== 1'b0 || out_data_a !== 8'h00) begin
         errors++; $display("FAIL rstmid_out: got %b/%h want 0/00", out_valid_a, out_data_a);
      end
      checks++;
      if (word_cnt_a !== exp_cnt_a || word_cnt_b !== exp_cnt_b) begin
         errors++; $display("FAIL rstmid_cnt: got %0d/%0d want 0/0", word_cnt_a, word_cnt_b);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #2;
         checks++;
         if (rinc_a !== 1'b0 || out_valid_a !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle cyc %0d: got %b/%b want 0/0", k, rinc_a, out_valid_a);
         end
      end
   endtask

   task automatic test_cnt_wrap();
      logic [7:0] w;
      int got = 0;
      @(posedge clk); #1;
      out_ready_a = 1'b1;
      for (int i = 0; i < 17; i++) begin
         w = 8'(8'hD0 + i);
         mem_a[wp_a] = w; wp_a = wp_a + 8'd1; sb_a.push_back(w);
      end
      for (int k = 0; k < 60 && got < 17; k++) begin
         #1;
         checks++;
         if (word_cnt_a !== exp_cnt_a) begin
            errors++; $display("FAIL wrap_cnt_run cyc %0d: got %0d want %0d", k, word_cnt_a, exp_cnt_a);
         end
         if (out_valid_a === 1'b1) begin
            got++;
            checks++;
            if (sb_a.size() == 0) begin
               errors++; $display("FAIL wrap_data: got unexpected %h want none", out_data_a);
            end else begin
               w = sb_a.pop_front();
               if (out_data_a !== w) begin
                  errors++; $display("FAIL wrap_data: got %h want %h", out_data_a, w);
               end
            end
            exp_cnt_a = exp_cnt_a + 4'd1;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (got != 17) begin
         errors++; $display("FAIL wrap_timeout: got %0d handshakes want 17", got);
      end
      #1;
      checks++;
      if (word_cnt_a !== exp_cnt_a) begin
         errors++; $display("FAIL wrap_cnt: got %0d want %0d", word_cnt_a, exp_cnt_a);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_cnt_a = 4'd0;
      exp_cnt_b = 16'd0;
      rst = 1'b1;
      wp_a = 8'd0;
      wp_b = 8'd0;
      out_ready_a = 1'b1;
      out_ready_b = 1'b1;
      force_empty_b = 1'b0;
      test_reset();
      test_stream_lat1();
      test_backpressure();
      test_alternating_empty();
      test_reset_mid();
      test_cnt_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
